// File: rtl/sprite_pkg.sv
// Shared sprite command types and widths for the SPI decoder, sprite_queue and sprite_driver.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package sprite_pkg;

    localparam int ID_W               = 8;
    localparam int COORD_W            = 16;
    localparam int SCALE_W            = 8;
    localparam int SPRITE_QUEUE_DEPTH = 64;

    // One draw command as stored in the queue and consumed by sprite_driver.
    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SCALE_W-1:0] scale;
    } sprite_cmd_t;

endpackage

// File: rtl/sprite_queue_if.sv
// Producer/consumer bundle of sprite_queue; the master side is the decoder plus driver, the slave side is the queue.
// Latency: none (wiring only).
// Backpressure: enq_ready from the queue; optional stats ports exist only with SPRITE_QUEUE_STATS_EN.
interface sprite_queue_if
    import sprite_pkg::*;
#(
    parameter int DEPTH = SPRITE_QUEUE_DEPTH
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic               enq_valid;
    logic               enq_ready;
    logic [ID_W-1:0]    enq_id;
    logic [COORD_W-1:0] enq_x;
    logic [COORD_W-1:0] enq_y;
    logic [SCALE_W-1:0] enq_scale;
    logic               commit;
    logic               abort;
    logic               dequeue;
    logic               is_empty;
    logic [ID_W-1:0]    sprite_id;
    logic [COORD_W-1:0] sprite_x;
    logic [COORD_W-1:0] sprite_y;
    logic [SCALE_W-1:0] sprite_scale;
    logic [PW-1:0]      count;
    logic               overflow;
`ifdef SPRITE_QUEUE_STATS_EN
    logic [15:0]        drop_count;
    logic [PW-1:0]      peak_fill;
`endif

    modport master (
        output enq_valid, enq_id, enq_x, enq_y, enq_scale, commit, abort, dequeue,
        input  enq_ready, is_empty, sprite_id, sprite_x, sprite_y, sprite_scale, count, overflow
`ifdef SPRITE_QUEUE_STATS_EN
        , input drop_count, peak_fill
`endif
    );

    modport slave (
        input  enq_valid, enq_id, enq_x, enq_y, enq_scale, commit, abort, dequeue,
        output enq_ready, is_empty, sprite_id, sprite_x, sprite_y, sprite_scale, count, overflow
`ifdef SPRITE_QUEUE_STATS_EN
        , output drop_count, peak_fill
`endif
    );

endinterface

// File: rtl/sprite_cmd_ram.sv
// Command storage: DEPTH x sprite_cmd_t with a synchronous write port and an asynchronous read port.
// Latency: write lands at the clock edge; read data follows raddr combinationally.
// Backpressure: none; the caller only writes free slots.
module sprite_cmd_ram
    import sprite_pkg::*;
#(
    parameter int DEPTH = SPRITE_QUEUE_DEPTH
) (
    input  logic                     clock,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  sprite_cmd_t              i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output sprite_cmd_t              o_rdata
);

    sprite_cmd_t r_mem [DEPTH];

    // Write port; contents need no reset because the pointers decide what is valid.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sprite_queue.sv
// Frame-committed show-ahead FIFO of sprite commands; enqueues stay hidden until commit, abort discards them.
// Latency: a committed command is visible the cycle after commit; the next head is visible the cycle after dequeue.
// Backpressure: enq_ready low when full, enqueue while full is dropped and sets sticky overflow. Stats: SPRITE_QUEUE_STATS_EN.
module sprite_queue
    import sprite_pkg::*;
#(
    parameter int DEPTH = SPRITE_QUEUE_DEPTH
) (
    input  logic       clock,
    input  logic       reset,
    sprite_queue_if.slave q
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_cm_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_count;
    logic          r_overflow;

    logic [PW-1:0] w_fill;
    logic [PW-1:0] w_wr_inc;
    logic [PW-1:0] w_wr_nxt;
    logic [PW-1:0] w_cm_nxt;
    logic [PW-1:0] w_rd_nxt;
    logic          w_full;
    logic          w_empty;
    logic          w_enq_acc;
    logic          w_enq_drop;
    logic          w_deq;
    sprite_cmd_t   w_wdata;
    sprite_cmd_t   w_rdata;

    assign w_fill     = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_fill == PW'(DEPTH));
    assign w_empty    = (r_rd_ptr == r_cm_ptr);
    // Abort wins over a same-cycle enqueue and does not count it as an overflow drop.
    assign w_enq_acc  = q.enq_valid && !w_full && !q.abort;
    assign w_enq_drop = q.enq_valid &&  w_full && !q.abort;
    assign w_deq      = q.dequeue && !w_empty;

    // Next pointers: commit takes the post-enqueue write pointer, abort rewinds to the commit boundary.
    always_comb begin
        w_wr_inc = r_wr_ptr + {{(PW-1){1'b0}}, w_enq_acc};
        w_wr_nxt = w_wr_inc;
        w_cm_nxt = r_cm_ptr;
        w_rd_nxt = r_rd_ptr + {{(PW-1){1'b0}}, w_deq};
        if (q.abort) begin
            w_wr_nxt = r_cm_ptr;
        end else if (q.commit) begin
            w_cm_nxt = w_wr_inc;
        end
    end

    // Pointer, count and sticky overflow registers; count tracks the next pointers so it never lags.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_cm_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_cm_ptr <= w_cm_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cm_nxt - w_rd_nxt;
            if (w_enq_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_wdata = '{id: q.enq_id, x: q.enq_x, y: q.enq_y, scale: q.enq_scale};

    sprite_cmd_ram #(.DEPTH(DEPTH)) u_ram (
        .clock   (clock),
        .i_we    (w_enq_acc),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    assign q.enq_ready    = !w_full;
    assign q.is_empty     = w_empty;
    assign q.sprite_id    = w_rdata.id;
    assign q.sprite_x     = w_rdata.x;
    assign q.sprite_y     = w_rdata.y;
    assign q.sprite_scale = w_rdata.scale;
    assign q.count        = r_count;
    assign q.overflow     = r_overflow;

`ifdef SPRITE_QUEUE_STATS_EN
    logic [15:0]   r_drop_count;
    logic [PW-1:0] r_peak_fill;
    logic [PW-1:0] w_fill_nxt;

    assign w_fill_nxt = w_wr_nxt - w_rd_nxt;

    // Saturating drop counter and high-water mark of occupancy, both cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_drop_count <= '0;
            r_peak_fill  <= '0;
        end else begin
            if (w_enq_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
            if (w_fill_nxt > r_peak_fill) begin
                r_peak_fill <= w_fill_nxt;
            end
        end
    end

    assign q.drop_count = r_drop_count;
    assign q.peak_fill  = r_peak_fill;
`endif

endmodule

// File: tb/tb_sprite_queue.sv
// Directed bench for sprite_queue at DEPTH=4: table of single-cycle vectors plus a wrap-around sequence.
// Latency: expectations are sampled 1 time unit after the rising edge that applied each vector.
// Backpressure: the wrap sequence only offers commands when its model says a slot is free.
module tb_sprite_queue;
    import sprite_pkg::*;

    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sprite_queue_if #(.DEPTH(DEPTH)) qif ();

    sprite_queue #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .q     (qif)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit rst; bit ev; int id; bit cm; bit ab; bit dq;
        bit e_empty; bit e_rdy; int e_cnt; bit e_ovf; int e_id;
        bit cs; int e_drop; int e_peak;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit rst, bit ev, int id, bit cm, bit ab, bit dq,
                                bit e_empty, bit e_rdy, int e_cnt, bit e_ovf, int e_id,
                                bit cs, int e_drop, int e_peak);
        vec_t v;
        v.rst = rst; v.ev = ev; v.id = id; v.cm = cm; v.ab = ab; v.dq = dq;
        v.e_empty = e_empty; v.e_rdy = e_rdy; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_id = e_id;
        v.cs = cs; v.e_drop = e_drop; v.e_peak = e_peak;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Command fields derive from the id: x = 10*id, y = 10*id+1, scale = id.
    task automatic drive(input bit r, input bit ev, input int id, input bit cm, input bit ab, input bit dq);
        reset         = r;
        qif.enq_valid = ev;
        qif.enq_id    = 8'(id);
        qif.enq_x     = 16'(id * 10);
        qif.enq_y     = 16'(id * 10 + 1);
        qif.enq_scale = 8'(id);
        qif.commit    = cm;
        qif.abort     = ab;
        qif.dequeue   = dq;
    endtask

    task automatic check_head(input string tag, input int id);
        check({tag, " id"},    qif.sprite_id,    id);
        check({tag, " x"},     qif.sprite_x,     id * 10);
        check({tag, " y"},     qif.sprite_y,     id * 10 + 1);
        check({tag, " scale"}, qif.sprite_scale, id);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int comm[$];
        int pend[$];
        int nxt;
        int got;
        int cyc;
        bit ev, cm, dq;

        drive(1, 0, 0, 0, 0, 0);

        //            rst ev id cm ab dq  empty rdy cnt ovf id  cs drop peak
        // Reset state
        vq.push_back(mk(1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0,  1, 0, 0));
        // Commit gating
        vq.push_back(mk(0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0,  0, 0, 0));
        vq.push_back(mk(0, 1, 2, 0, 0, 0,  1, 1, 0, 0, 0,  0, 0, 0));
        vq.push_back(mk(0, 1, 3, 0, 0, 0,  1, 1, 0, 0, 0,  0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 0, 0,  0, 1, 3, 0, 1,  0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1,  0, 1, 2, 0, 2,  0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 3,  0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0,  0, 0, 0));
        // Abort: 6,7 discarded, same-cycle 8 + abort dropped without overflow
        vq.push_back(mk(0, 1, 5, 1, 0, 0,  0, 1, 1, 0, 5,  0, 0, 0));
        vq.push_back(mk(0, 1, 6, 0, 0, 0,  0, 1, 1, 0, 5,  0, 0, 0));
        vq.push_back(mk(0, 1, 7, 0, 0, 0,  0, 1, 1, 0, 5,  0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1, 0,  0, 1, 1, 0, 5,  0, 0, 0));
        vq.push_back(mk(0, 1, 8, 1, 1, 0,  0, 1, 1, 0, 5,  0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0,  0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0,  0, 0, 0));
        // Full and overflow
        vq.push_back(mk(0, 1, 11, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0));
        vq.push_back(mk(0, 1, 12, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0));
        vq.push_back(mk(0, 1, 13, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0));
        vq.push_back(mk(0, 1, 14, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 0, 0,  0, 0, 4, 0, 11, 0, 0, 0));
        vq.push_back(mk(0, 1, 9, 0, 0, 0,  0, 0, 4, 1, 11, 1, 1, 4));
        // Enqueue alongside dequeue while full: still dropped, dequeue happens
        vq.push_back(mk(0, 1, 9, 0, 0, 1,  0, 1, 3, 1, 12, 1, 2, 4));
        vq.push_back(mk(0, 1, 9, 0, 0, 0,  0, 0, 3, 1, 12, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 0, 0,  0, 0, 4, 1, 12, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1,  0, 1, 3, 1, 13, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1,  0, 1, 2, 1, 14, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1,  0, 1, 1, 1, 9,  0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1,  1, 1, 0, 1, 0,  1, 2, 4));
        // Same-cycle enqueue + commit, dequeue while empty
        vq.push_back(mk(0, 1, 4, 1, 0, 0,  0, 1, 1, 1, 4,  0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1,  1, 1, 0, 1, 0,  0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1,  1, 1, 0, 1, 0,  0, 0, 0));
        // Reset mid-operation: 2 committed + 1 pending, reset beats all inputs
        vq.push_back(mk(0, 1, 21, 0, 0, 0, 1, 1, 0, 1, 0,  0, 0, 0));
        vq.push_back(mk(0, 1, 22, 1, 0, 0, 0, 1, 2, 1, 21, 0, 0, 0));
        vq.push_back(mk(0, 1, 23, 0, 0, 0, 0, 1, 2, 1, 21, 0, 0, 0));
        vq.push_back(mk(1, 1, 24, 1, 0, 1, 1, 1, 0, 0, 0,  1, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0,  1, 0, 0));

        foreach (vq[i]) begin
            @(negedge clock);
            drive(vq[i].rst, vq[i].ev, vq[i].id, vq[i].cm, vq[i].ab, vq[i].dq);
            @(posedge clock);
            #1;
            check($sformatf("v%0d is_empty", i),  qif.is_empty,  vq[i].e_empty);
            check($sformatf("v%0d enq_ready", i), qif.enq_ready, vq[i].e_rdy);
            check($sformatf("v%0d count", i),     qif.count,     vq[i].e_cnt);
            check($sformatf("v%0d overflow", i),  qif.overflow,  vq[i].e_ovf);
            if (!vq[i].e_empty) begin
                check_head($sformatf("v%0d head", i), vq[i].e_id);
            end
`ifdef SPRITE_QUEUE_STATS_EN
            if (vq[i].cs) begin
                check($sformatf("v%0d drop_count", i), qif.drop_count, vq[i].e_drop);
                check($sformatf("v%0d peak_fill", i),  qif.peak_fill,  vq[i].e_peak);
            end
`endif
        end

        // Wrap-around: 3*DEPTH+1 commands committed in batches of 3 while the consumer drains.
        @(negedge clock);
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0);
        nxt = 0;
        got = 0;
        cyc = 0;
        while (got < 3 * DEPTH + 1 && cyc < 200) begin
            @(negedge clock);
            ev = (nxt < 3 * DEPTH + 1) && (comm.size() + pend.size() < DEPTH);
            dq = (comm.size() > 0);
            cm = ((pend.size() + int'(ev)) >= 3) ||
                 ((nxt + int'(ev) == 3 * DEPTH + 1) && (pend.size() + int'(ev) > 0));
            if (dq) begin
                check_head("wrap head", comm[0]);
            end
            drive(0, ev, 100 + nxt, cm, 0, dq);
            @(posedge clock);
            #1;
            if (dq) begin
                void'(comm.pop_front());
                got++;
            end
            if (ev) begin
                pend.push_back(100 + nxt);
                nxt++;
            end
            if (cm) begin
                while (pend.size() > 0) comm.push_back(pend.pop_front());
            end
            check("wrap is_empty",  qif.is_empty,  (comm.size() == 0));
            check("wrap count",     qif.count,     comm.size());
            check("wrap enq_ready", qif.enq_ready, (comm.size() + pend.size() < DEPTH));
            check("wrap overflow",  qif.overflow,  0);
            cyc++;
        end
        check("wrap dequeued total", got, 3 * DEPTH + 1);

        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
